// File: rtl/kb_uart_bridge.sv
// kb_uart_bridge
//   Sequential bridge between a first-word-fall-through byte FIFO (PS/2
//   keyboard buffer) and a byte-wide UART transmitter. Each source byte is
//   popped once and then emitted in one of two formats, chosen when the byte
//   is fetched:
//     raw: the byte itself. With CRLF_EXPAND=1, 8'h0D is followed by 8'h0A.
//     hex: two uppercase ASCII hex digits, then SEP_CHAR. After every
//          LINE_LEN pairs, CR+LF is sent in place of the separator.
//   A one-cycle guard after every write means a transmitter whose tx_empty
//   flag lags by a cycle never receives a double write.
//
// Parameters
//   SEP_CHAR    byte sent after each hex pair
//   LINE_LEN    hex pairs per line before CR+LF (1..255)
//   CRLF_EXPAND raw mode: 1 = expand 8'h0D to 8'h0D 8'h0A
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   hex_mode   0 = raw, 1 = hex; sampled only when a byte is fetched
//   src_empty  source FIFO empty
//   src_data   source FIFO head byte (FWFT)
//   src_rd     one-cycle pop strobe to the source FIFO (registered)
//   tx_empty   UART can accept a byte
//   tx_wr      one-cycle write strobe to the UART (registered)
//   tx_byte    byte presented with tx_wr (registered)
//   busy       high whenever the FSM is not in IDLE
//
// Optional feature macro: KB_BRIDGE_STATS_EN
//   When defined, adds byte_count[15:0] (counts src_rd pulses) and
//   tx_count[15:0] (counts tx_wr pulses). Both wrap and are cleared by rst.
module kb_uart_bridge #(
  parameter logic [7:0] SEP_CHAR    = 8'h20,
  parameter int         LINE_LEN    = 16,
  parameter int         CRLF_EXPAND = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hex_mode,
  input  logic        src_empty,
  input  logic [7:0]  src_data,
  output logic        src_rd,
  input  logic        tx_empty,
  output logic        tx_wr,
  output logic [7:0]  tx_byte,
  output logic        busy
`ifdef KB_BRIDGE_STATS_EN
  ,
  output logic [15:0] byte_count,
  output logic [15:0] tx_count
`endif
);

  localparam logic [7:0] LINE_LEN_B = 8'(LINE_LEN);
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  // EMIT1 is the first emit of every byte: the raw byte in raw mode, the
  // high hex digit in hex mode. EMIT_LO onwards are hex-only except EMIT_LF,
  // which also serves the raw CR expansion.
  typedef enum logic [2:0] {
    IDLE,
    EMIT1,
    EMIT_LO,
    EMIT_SEP,
    EMIT_CR,
    EMIT_LF
  } state_t;

  state_t      state;
  state_t      nxt_state;
  logic [7:0]  hold;
  logic        mode_q;
  logic        guard;
  logic [7:0]  line_cnt;
  logic [7:0]  cnt_nxt;
  logic [7:0]  cur_byte;
  logic [7:0]  cnt_inc;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h3, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

  assign busy    = (state != IDLE);
  assign cnt_inc = line_cnt + 8'd1;

  // Byte to send and where to go once it is sent, for the current state.
  // The line counter only advances on the low hex digit.
  always_comb begin
    cur_byte  = hold;
    nxt_state = IDLE;
    cnt_nxt   = line_cnt;
    case (state)
      EMIT1: begin
        if (mode_q) begin
          cur_byte  = hex_ascii(hold[7:4]);
          nxt_state = EMIT_LO;
        end else begin
          cur_byte  = hold;
          nxt_state = ((CRLF_EXPAND != 0) && (hold == CHAR_CR)) ? EMIT_LF : IDLE;
        end
      end
      EMIT_LO: begin
        cur_byte = hex_ascii(hold[3:0]);
        if (cnt_inc == LINE_LEN_B) begin
          cnt_nxt   = 8'd0;
          nxt_state = EMIT_CR;
        end else begin
          cnt_nxt   = cnt_inc;
          nxt_state = EMIT_SEP;
        end
      end
      EMIT_SEP: begin
        cur_byte  = SEP_CHAR;
        nxt_state = IDLE;
      end
      EMIT_CR: begin
        cur_byte  = CHAR_CR;
        nxt_state = EMIT_LF;
      end
      EMIT_LF: begin
        cur_byte  = CHAR_LF;
        nxt_state = IDLE;
      end
      default: begin
        cur_byte  = hold;
        nxt_state = IDLE;
      end
    endcase
  end

  // Main FSM. Strobes default low so each is a single-cycle pulse. In any
  // emit state a write happens only when the UART is ready and the guard
  // from the previous write has expired; otherwise state and tx_byte hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      src_rd   <= 1'b0;
      tx_wr    <= 1'b0;
      tx_byte  <= 8'h00;
      hold     <= 8'h00;
      mode_q   <= 1'b0;
      guard    <= 1'b0;
      line_cnt <= 8'd0;
`ifdef KB_BRIDGE_STATS_EN
      byte_count <= 16'd0;
      tx_count   <= 16'd0;
`endif
    end else begin
      src_rd <= 1'b0;
      tx_wr  <= 1'b0;
      guard  <= 1'b0;
      if (state == IDLE) begin
        if (!src_empty) begin
          src_rd <= 1'b1;
          hold   <= src_data;
          mode_q <= hex_mode;
          state  <= EMIT1;
`ifdef KB_BRIDGE_STATS_EN
          byte_count <= byte_count + 16'd1;
`endif
        end
      end else if (tx_empty && !guard) begin
        tx_wr    <= 1'b1;
        tx_byte  <= cur_byte;
        guard    <= 1'b1;
        state    <= nxt_state;
        line_cnt <= cnt_nxt;
`ifdef KB_BRIDGE_STATS_EN
        tx_count <= tx_count + 16'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_kb_uart_bridge.sv
// tb_kb_uart_bridge
//   Directed bench for kb_uart_bridge (LINE_LEN=2, CRLF_EXPAND=1). A queue
//   models the FWFT source FIFO; the byte sequence each stimulus should
//   produce on the UART side is written out literally into a scoreboard
//   queue and popped as tx_wr pulses appear. Also exercises the
//   KB_BRIDGE_STATS_EN counters when that macro is defined.
module tb_kb_uart_bridge;

  localparam int LINE_LEN = 2;

  logic        clk;
  logic        rst;
  logic        hex_mode;
  logic        src_empty;
  logic [7:0]  src_data;
  logic        src_rd;
  logic        tx_empty;
  logic        tx_wr;
  logic [7:0]  tx_byte;
  logic        busy;
`ifdef KB_BRIDGE_STATS_EN
  logic [15:0] byte_count;
  logic [15:0] tx_count;
`endif

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic        prev_wr;
  int          total;
  int          bad;

  kb_uart_bridge #(
    .SEP_CHAR(8'h20),
    .LINE_LEN(LINE_LEN),
    .CRLF_EXPAND(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hex_mode(hex_mode),
    .src_empty(src_empty),
    .src_data(src_data),
    .src_rd(src_rd),
    .tx_empty(tx_empty),
    .tx_wr(tx_wr),
    .tx_byte(tx_byte),
    .busy(busy)
`ifdef KB_BRIDGE_STATS_EN
    ,
    .byte_count(byte_count),
    .tx_count(tx_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef KB_BRIDGE_STATS_EN
  task automatic checkWord(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  task automatic refreshSrc();
    src_empty = (fifo_q.size() == 0);
    src_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic hx);
    hex_mode = hx;
    fifo_q.push_back(b);
    refreshSrc();
  endtask

  // Bytes are listed left to right in the low n bytes of seq.
  task automatic expectSeq(input logic [79:0] seq, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(seq[8*(n-1-i) +: 8]);
  endtask

  // One clock cycle, sampled at the falling edge: score any write, pop the
  // FIFO model on a read strobe.
  task automatic stepCycle();
    @(negedge clk);
    if (tx_wr) begin
      checkBit("tx_gap", prev_wr, 1'b0);
      checkBit("tx_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) checkOutput("tx_byte", tx_byte, exp_q.pop_front());
    end
    if (src_rd) begin
      checkBit("src_rd_nonempty", fifo_q.size() != 0, 1'b1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      refreshSrc();
    end
    prev_wr = tx_wr;
  endtask

  task automatic waitDone(input string tag, input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      stepCycle();
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    checkBit(tag, done, 1'b1);
    repeat (3) stepCycle();
  endtask

  task automatic waitWrite(input string tag);
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      if (tx_wr) break;
    end
    checkBit(tag, tx_wr, 1'b1);
  endtask

  task automatic waitRead(input string tag);
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      if (src_rd) break;
    end
    checkBit(tag, src_rd, 1'b1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    prev_wr  = 1'b0;
    clk      = 1'b0;
    rst      = 1'b1;
    hex_mode = 1'b0;
    tx_empty = 1'b1;
    refreshSrc();

    repeat (3) @(negedge clk);
    checkBit("rst_src_rd", src_rd, 1'b0);
    checkBit("rst_tx_wr", tx_wr, 1'b0);
    checkOutput("rst_tx_byte", tx_byte, 8'h00);
    checkBit("rst_busy", busy, 1'b0);
    rst = 1'b0;
    stepCycle();
    stepCycle();

    $display("[TB] raw byte latency");
    applyStimulus(8'h41, 1'b0);
    expectSeq(80'h41, 1);
    stepCycle();
    checkBit("lat_src_rd", src_rd, 1'b1);
    checkBit("lat_wr_early", tx_wr, 1'b0);
    checkBit("lat_busy", busy, 1'b1);
    stepCycle();
    checkBit("lat_wr", tx_wr, 1'b1);
    checkBit("lat_idle", busy, 1'b0);
    waitDone("raw41_done", 50);

    $display("[TB] raw CR expansion");
    applyStimulus(8'h0D, 1'b0);
    expectSeq(80'h0D0A, 2);
    waitDone("raw_cr_done", 50);

    $display("[TB] hex 3A F0");
    applyStimulus(8'h3A, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    expectSeq(80'h334120_4630_0D0A, 7);
    waitDone("hex_pair_done", 100);

    $display("[TB] hex line wrap");
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h01, 1'b1);
    expectSeq(80'h303120_3031_0D0A_303120, 10);
    waitDone("wrap_done", 100);

    $display("[TB] raw byte keeps line counter");
    applyStimulus(8'h55, 1'b0);
    expectSeq(80'h55, 1);
    waitDone("raw55_done", 50);
    applyStimulus(8'h7E, 1'b1);
    expectSeq(80'h3745_0D0A, 4);
    waitDone("hex7e_done", 50);

    $display("[TB] mode change mid-byte");
    applyStimulus(8'hC3, 1'b1);
    expectSeq(80'h433320, 3);
    waitRead("c3_fetch");
    applyStimulus(8'h0D, 1'b0);
    expectSeq(80'h0D0A, 2);
    waitDone("mode_flip_done", 100);

    $display("[TB] transmitter stall");
    applyStimulus(8'hA5, 1'b1);
    expectSeq(80'h4135_0D0A, 4);
    waitWrite("stall_first_wr");
    tx_empty = 1'b0;
    applyStimulus(8'h42, 1'b0);
    expectSeq(80'h42, 1);
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      checkBit("stall_tx_wr", tx_wr, 1'b0);
      checkBit("stall_src_rd", src_rd, 1'b0);
      checkOutput("stall_tx_byte", tx_byte, 8'h41);
    end
    tx_empty = 1'b1;
    waitDone("stall_done", 100);

    $display("[TB] reset mid-byte");
    applyStimulus(8'h99, 1'b1);
    expectSeq(80'h393920, 3);
    waitDone("hex99_done", 50);
    applyStimulus(8'h88, 1'b1);
    expectSeq(80'h38, 1);
    waitWrite("pre_rst_wr");
    rst = 1'b1;
    #1;
    checkBit("midrst_tx_wr", tx_wr, 1'b0);
    checkBit("midrst_src_rd", src_rd, 1'b0);
    checkOutput("midrst_tx_byte", tx_byte, 8'h00);
    checkBit("midrst_busy", busy, 1'b0);
    exp_q.delete();
    prev_wr = 1'b0;
    repeat (2) stepCycle();
    rst = 1'b0;
    repeat (10) stepCycle();
    checkBit("post_rst_busy", busy, 1'b0);

    $display("[TB] raw burst");
    applyStimulus(8'h61, 1'b0);
    applyStimulus(8'h62, 1'b0);
    applyStimulus(8'h0D, 1'b0);
    applyStimulus(8'h63, 1'b0);
    applyStimulus(8'h64, 1'b0);
    expectSeq(80'h6162_0D0A_6364, 6);
    waitDone("burst_done", 100);
`ifdef KB_BRIDGE_STATS_EN
    checkWord("byte_count", byte_count, 16'd5);
    checkWord("tx_count", tx_count, 16'd6);
`endif

    $display("[TB] line counter cleared by reset");
    applyStimulus(8'h12, 1'b1);
    expectSeq(80'h313220, 3);
    waitDone("hex12_done", 50);
    applyStimulus(8'h34, 1'b1);
    expectSeq(80'h3334_0D0A, 4);
    waitDone("hex34_done", 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kb_uart_bridge.md
Name: kb_uart_bridge

Overview:
Sequential bridge between a first-word-fall-through byte FIFO (PS/2 keyboard buffer) and a byte-wide UART transmitter. It replaces the single-cycle combinational read/write glue. It adds a runtime raw/hex formatting mode, CR to CR+LF expansion, hex-mode line wrapping, and a guard cycle so that a lagging transmitter "empty" flag never causes a double write.

Parameters:
SEP_CHAR, 8'h20, ASCII byte emitted after each hex pair in hex mode.
LINE_LEN, 16, hex pairs per line before an automatic CR+LF; legal range 1..255.
CRLF_EXPAND, 1, raw mode only: 1 = source byte 8'h0D is emitted as 8'h0D then 8'h0A; 0 = passed through unchanged.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
hex_mode  in  1  0 = raw bytes, 1 = two uppercase ASCII hex digits per byte; sampled only at fetch
src_empty  in  1  source FIFO empty
src_data  in  8  source FIFO head byte (FWFT, valid while src_empty=0)
src_rd  out  1  one-cycle pop strobe to the source FIFO
tx_empty  in  1  UART ready to accept a byte
tx_wr  out  1  one-cycle write strobe to the UART
tx_byte  out  8  byte presented with tx_wr
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; src_rd=0; tx_wr=0; tx_byte=8'h00; busy=0; hold register=0; line counter=0; guard=0.
- Outputs tx_wr, tx_byte and src_rd are registered.
- IDLE:
  - If src_empty=0, assert src_rd for exactly one cycle.
  - Capture src_data into the hold register and latch hex_mode into mode_q.
  - Go to EMIT1.
  - Each byte is popped exactly once. There is never more than one byte in flight.
- Emit rule, applied in every EMIT state:
  - tx_wr is asserted for one cycle only when tx_empty=1 and guard=0.
  - Each tx_wr sets guard=1 for the following cycle. No two tx_wr pulses are ever adjacent.
  - While tx_empty=0 the state and tx_byte hold.
- Raw mode (mode_q=0):
  - EMIT1 emits the hold byte.
  - If CRLF_EXPAND=1 and the byte is 8'h0D, go to EMIT_LF (emit 8'h0A). Otherwise return to IDLE.
  - The line counter is not used.
- Hex mode (mode_q=1):
  - EMIT_HI emits hold[7:4] as ASCII; EMIT_LO emits hold[3:0] as ASCII.
  - Digit mapping: 0-9 map to 8'h30-8'h39; A-F map to 8'h41-8'h46.
  - Next the line counter increments.
  - If the counter reaches LINE_LEN, clear it and go EMIT_CR (8'h0D), then EMIT_LF (8'h0A). The separator is not emitted in this case.
  - Otherwise go to EMIT_SEP (SEP_CHAR).
  - Then return to IDLE.
- Best-case throughput: one tx_wr every 2 cycles. Source-to-first-tx_wr latency is 2 cycles (src_rd cycle, then EMIT1 with tx_wr) when tx_empty=1.
- Changing hex_mode mid-byte does not affect the byte in progress.
- Toggling hex_mode from 1 to 0 leaves the line counter as-is. It resumes on the next hex byte.
- src_empty rising during emission has no effect. src_rd is never asserted while src_empty=1.
- Reset mid-operation: the byte in flight is discarded and no further tx_wr is issued. The source FIFO is not re-read.
- Line counter width: 8 bits; compare is equality with LINE_LEN.

Optional Feature:
KB_BRIDGE_STATS_EN:
- Defined: adds output port byte_count [15:0].
  - It is incremented on every src_rd and wraps from 16'hFFFF to 0.
  - It is cleared by rst.
  - Adds output port tx_count [15:0], incremented on every tx_wr under the same wrap and reset rules.
- Undefined: neither port nor its counters exist. All other behaviour is identical.

Test Plan:
- Raw mode, FIFO holds 8'h41, tx_empty=1 always -> one src_rd, then tx_wr with tx_byte=8'h41 two cycles after src_empty falls; busy returns to 0.
- Raw mode, CRLF_EXPAND=1, byte 8'h0D -> tx_wr sequence 8'h0D, 8'h0A, separated by at least one idle cycle.
- Hex mode, bytes 8'h3A and 8'hF0 -> tx bytes 33 41 20 46 30 20 (hex).
- Hex mode, LINE_LEN=2, three bytes 8'h01 -> 30 31 20 30 31 0D 0A 30 31 20; line counter ends at 1.
- tx_empty held low 20 cycles mid-byte -> tx_byte stable, no tx_wr, no src_rd; output completes once tx_empty rises. Asserting rst mid-EMIT_LO -> all outputs 0 immediately and no further tx_wr.
- With KB_BRIDGE_STATS_EN defined: five raw bytes with one 8'h0D -> byte_count=5, tx_count=6.
